// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a single-cycle instruction
// memory and queues {pc, instr} pairs in a 2-entry prefetch buffer for decode.
module fetch_sequencer #(
  parameter logic [31:0] reset_vector = 32'h0000_0000,
  parameter int unsigned mem_bytes    = 128,
  parameter int unsigned depth        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        running,
  output logic        fault,
  output logic [31:0] retired_count,
  output logic [1:0]  state_dbg
);

  // Handshake: a transfer to decode completes in any cycle where out_valid and
  // out_ready are both high at the rising edge; out_valid never depends on out_ready.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] head_pc, head_instr;
  logic [31:0] tail_pc, tail_instr;

  logic pop;
  logic pc_legal;
  logic fire;
  logic flush;
  logic load_pc;
  logic unused_target_bits;

  assign unused_target_bits = ^redirect_target[1:0];

  assign instr_address   = pc;
  assign out_valid       = (count != 2'd0);
  assign out_pc          = out_valid ? head_pc : 32'd0;
  assign out_instruction = out_valid ? head_instr : 32'd0;
  assign running         = (state == S_RUN);
  assign state_dbg       = state;

  assign pop      = out_valid && out_ready;
  assign pc_legal = (pc < mem_bytes);
  assign fire     = (state == S_RUN) && !redirect_valid && pc_legal &&
                    ((count < 2'd2) || pop);
  assign flush    = redirect_valid && ((state == S_RUN) || (state == S_HALTED));
  assign load_pc  = redirect_valid && (state != S_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= reset_vector;
      count         <= 2'd0;
      head_pc       <= 32'd0;
      head_instr    <= 32'd0;
      tail_pc       <= 32'd0;
      tail_instr    <= 32'd0;
      fault         <= 1'b0;
      retired_count <= 32'd0;
    end else begin
      if (load_pc) begin
        pc <= {redirect_target[31:2], 2'b00};
      end else if (fire) begin
        pc <= pc + 32'd4;
      end

      if (pop) begin
        retired_count <= retired_count + 32'd1;
      end

      // The head register always holds the oldest entry; the tail only the second.
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({fire, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_pc    <= pc;
              head_instr <= instr_data;
            end else begin
              tail_pc    <= pc;
              tail_instr <= instr_data;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            count      <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head_pc    <= pc;
              head_instr <= instr_data;
            end else begin
              head_pc    <= tail_pc;
              head_instr <= tail_instr;
              tail_pc    <= pc;
              tail_instr <= instr_data;
            end
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start && !halt) state <= S_RUN;
        end
        S_RUN: begin
          if (halt) begin
            state <= S_HALTED;
          end else if (!redirect_valid && !pc_legal) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        S_HALTED: begin
          if (start && !halt) state <= S_RUN;
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, all compared
// against a queue-based reference of the fetch/buffer behaviour.
module tb_fetch_sequencer;

  localparam int MEMB = 128;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] instr_address;
  logic [31:0] instr_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        running;
  logic        fault;
  logic [31:0] retired_count;
  logic [1:0]  state_dbg;

  logic [31:0] mem [0:31];

  int total = 0;
  int bad = 0;

  // reference state
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  int          m_mode;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .instr_address(instr_address), .instr_data(instr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .running(running), .fault(fault), .retired_count(retired_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign instr_data = mem[instr_address[6:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc      = 32'd0;
    m_retired = 32'd0;
    m_mode    = M_IDLE;
  endtask

  task automatic model_step(input logic s, input logic h, input logic rv,
                            input logic [31:0] rt, input logic rdy);
    int          sz;
    logic        do_pop;
    logic        do_fetch;
    logic [31:0] old_pc;
    sz       = exp_q.size();
    old_pc   = m_pc;
    do_pop   = (sz > 0) && rdy;
    do_fetch = (m_mode == M_RUN) && !rv && (m_pc < MEMB) && ((sz < 2) || do_pop);
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_retired = m_retired + 32'd1;
    end
    if (rv && m_mode != M_FAULT) begin
      if (m_mode != M_IDLE) exp_q.delete();
      m_pc = {rt[31:2], 2'b00};
    end else if (do_fetch) begin
      exp_q.push_back({m_pc, mem[m_pc[6:2]]});
      m_pc = m_pc + 32'd4;
    end
    case (m_mode)
      M_IDLE:   if (s && !h) m_mode = M_RUN;
      M_RUN:    if (h) m_mode = M_HALTED;
                else if (!rv && old_pc >= MEMB) m_mode = M_FAULT;
      M_HALTED: if (s && !h) m_mode = M_RUN;
      default:  m_mode = M_FAULT;
    endcase
  endtask

  task automatic check_all();
    logic [63:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
    check("valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check("out_pc", out_pc, head[63:32]);
    check("out_instr", out_instruction, head[31:0]);
    check("addr", instr_address, m_pc);
    check("running", {31'd0, running}, {31'd0, m_mode == M_RUN});
    check("fault", {31'd0, fault}, {31'd0, m_mode == M_FAULT});
    check("retired", retired_count, m_retired);
  endtask

  task automatic step(input logic s, input logic h, input logic rv,
                      input logic [31:0] rt, input logic rdy);
    start = s; halt = h; redirect_valid = rv; redirect_target = rt; out_ready = rdy;
    model_step(s, h, rv, rt, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h2402_0008;
    mem[5] = 32'h0043_2020;
    model_reset();

    // basic streaming with decode always ready
    do_reset();
    check("rst_addr", instr_address, 32'h0);
    step(1, 0, 0, 0, 1);
    check("lat_valid0", {31'd0, out_valid}, 32'd0);
    check("lat_run", {31'd0, running}, 32'd1);
    step(0, 0, 0, 0, 1);
    check("lat_valid1", {31'd0, out_valid}, 32'd1);
    check("first_instr", out_instruction, 32'h2402_0008);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 0, 1);
      check("seq_pc", out_pc, k * 4);
      check("seq_ret", retired_count, k);
      if (k == 5) check("instr_14", out_instruction, 32'h0043_2020);
    end

    // backpressure then drain
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    check("bp_addr", instr_address, 32'h8);
    check("bp_pc", out_pc, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 1);
      check("bp_seq", out_pc, k * 4);
    end

    // redirect with a full buffer
    step(0, 0, 1, 32'h17, 0);
    check("rd_valid", {31'd0, out_valid}, 32'd0);
    check("rd_addr", instr_address, 32'h14);
    step(0, 0, 0, 0, 0);
    check("rd_pc", out_pc, 32'h14);
    check("rd_instr", out_instruction, 32'h0043_2020);

    // halt with two buffered, drain, start+halt, resume
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("halt_run", {31'd0, running}, 32'd0);
    step(0, 0, 0, 0, 1);
    check("halt_drain", out_pc, 32'h18);
    step(0, 0, 0, 0, 1);
    check("halt_empty", {31'd0, out_valid}, 32'd0);
    check("halt_addr", instr_address, 32'h1C);
    step(1, 1, 0, 0, 0);
    check("both_halt", {31'd0, running}, 32'd0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("resume_pc", out_pc, 32'h1C);

    // fault at the end of the image
    step(0, 0, 1, 32'h7C, 0);
    step(0, 0, 0, 0, 0);
    check("f_pc", out_pc, 32'h7C);
    step(0, 0, 0, 0, 0);
    check("f_flag", {31'd0, fault}, 32'd1);
    step(1, 0, 1, 32'h0, 0);
    check("f_ignore", instr_address, 32'h80);
    step(0, 0, 0, 0, 1);
    check("f_drained", {31'd0, out_valid}, 32'd0);
    do_reset();
    check("f_clear", {31'd0, fault}, 32'd0);

    // asynchronous reset with a full buffer
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_fault", {31'd0, fault}, 32'd0);
    check("ar_ret", retired_count, 32'd0);
    check("ar_addr", instr_address, 32'h0);
    do_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199, 0) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(99, 0) < 12,
             $urandom_range(99, 0) < 5,
             $urandom_range(99, 0) < 8,
             $urandom_range(140, 0),
             $urandom_range(99, 0) < 70);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the single-cycle-read instruction memory (32 words, byte address, word index = address bits [6:2]). It owns the program counter, drives the memory address, and captures each returned word with its PC into a 2-entry prefetch buffer. The buffer presents instructions to decode through a valid/ready handshake. It accepts branch/jump redirects from execute, supports start/halt control, and faults on fetches beyond the memory image.

Parameters:
ResetVector, 32'h0000_0000, PC value loaded on reset.
MemBytes, 128, size of instruction memory in bytes; a fetch is legal only when PC < MemBytes.
Depth, 2, prefetch buffer entries (fixed at 2; the parameter exists for documentation and checking only).

Ports:
Clock  in  1  single system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  pulse; IDLE/HALTED -> RUN.
Halt  in  1  level/pulse; RUN -> HALTED.
InstrAddress  out  32  byte address to instruction memory; always equals PC (combinational).
InstrData  in  32  instruction word returned combinationally for InstrAddress.
OutValid  out  1  buffer head valid.
OutReady  in  1  decode accepts head.
OutInstruction  out  32  head instruction; 0 when buffer empty.
OutPC  out  32  head PC; 0 when buffer empty.
RedirectValid  in  1  branch/jump taken this cycle.
RedirectTarget  in  32  new PC; bits [1:0] ignored (forced 0).
Running  out  1  state == RUN.
Fault  out  1  sticky out-of-range fetch flag.
RetiredCount  out  32  count of completed OutValid&OutReady transfers.

Behaviour:
- Reset (asynchronous, any time, including mid-operation) sets: PC = ResetVector, buffer empty, state IDLE, OutValid = 0, OutInstruction = 0, OutPC = 0, Running = 0, Fault = 0, RetiredCount = 0.
- States:
  - IDLE: no fetch. Start -> RUN.
  - RUN: fetch enabled. Halt -> HALTED. Illegal PC -> FAULT.
  - HALTED: no fetch; PC is held. Start -> RUN.
  - FAULT: no fetch; exits only on Reset.
  - Halt and Start asserted together: Halt wins (RUN stays -> HALTED; HALTED stays HALTED).
- Fetch fires in a cycle when all hold: state == RUN, RedirectValid == 0, PC < MemBytes, and (count < 2 or pop occurs this cycle).
  - On fire: push {PC, InstrData} at the clock edge; PC <= PC + 4.
  - Throughput is 1 instruction per cycle.
- Out-of-range: in RUN with PC >= MemBytes and no redirect, next state = FAULT, Fault <= 1. The buffer keeps draining normally.
- Pop happens on OutValid & OutReady.
  - RetiredCount += 1 per pop, wrapping at 2^32.
  - OutValid = (count != 0).
  - OutInstruction and OutPC come from the head register, not combinationally from InstrData.
- Simultaneous push and pop at count = 2: legal; count stays 2; order is preserved (FIFO).
- Redirect (RedirectValid = 1):
  - In RUN or HALTED: flush the buffer (count <= 0), PC <= {RedirectTarget[31:2], 2'b00}, no push that cycle. A pop in the same cycle is a completed transfer and is counted.
  - In IDLE: load PC only.
  - In FAULT: ignored.
  - Redirect takes priority over the out-of-range check in the same cycle. A target >= MemBytes is accepted and faults on the following RUN cycle.
- Latency: Start high in cycle 0 -> Running = 1 in cycle 1, fetch at end of cycle 1 -> OutValid = 1 in cycle 2 with OutPC = ResetVector. After a redirect in cycle n, the first target instruction is valid in cycle n+2.
- The PC increment wraps modulo 2^32. The range check catches any address at or above MemBytes before wrap matters.
- No instruction is ever dropped or duplicated except by a flush.

Test Plan:
1. Load the standard program image; Reset, Start pulse, OutReady = 1 -> OutValid rises 2 cycles after Start; OutPC = 0,4,8,... one per cycle; head at PC 0 = 32'h24020008; at PC 0x14 = 32'h00432020; RetiredCount increments each cycle.
2. Backpressure: Start with OutReady = 0 -> after 2 pushes InstrAddress holds 0x8, OutValid = 1, OutPC = 0. Raise OutReady -> OutPC sequence 0,4,8,0xC with no gap, loss or duplicate.
3. Redirect: RedirectValid with target 0x17 while buffer is full -> next cycle OutValid = 0 and InstrAddress = 0x14. The following cycle OutPC = 0x14, OutInstruction = 32'h00432020.
4. Halt in RUN with 2 buffered -> Running = 0, no fetch; both buffered entries drain on OutReady. A later Start resumes at the held PC. Start+Halt together -> stays HALTED.
5. Fault: redirect to 0x7C -> fetches 0x7C; PC 0x80 -> Fault = 1, state FAULT. Buffered 0x7C still drains; subsequent redirect and Start are ignored; Reset clears Fault.
6. Assert Reset asynchronously mid-cycle with a full buffer -> OutValid = 0, Fault = 0, RetiredCount = 0, InstrAddress = ResetVector immediately, without waiting for a clock edge.
